// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid pipeline register with flush,
// NOP bubbles and saturating stall/flush statistics.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake, in_ctrl/in_data beat
//   out_valid/out_ready    downstream handshake, out_ctrl/out_data
//   flush                  drop held and incoming beats
//   stall_cnt, flush_cnt   saturating statistics counters
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;
  logic              stall_inc;
  logic              flush_hit;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_fire & out_fire: ld_main_in = 1'b1;
            in_fire & !out_ready: begin
              state_nxt = TWO;
              ld_skid   = 1'b1;
            end
            out_fire & !in_fire: state_nxt = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs come from registered state only; out_ctrl
  // is masked so an empty stage presents a NOP downstream.
  always_comb begin
    in_ready  = !rst && (state != TWO);
    out_valid = (state == ONE) || (state == TWO);
    out_ctrl  = out_valid ? main_ctrl : '0;
    out_data  = main_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign stall_inc = out_valid & !out_ready & !flush;
  assign flush_hit = flush & ((state != EMPTY) | in_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_hit && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model checker plus directed
// scenarios for pipe_stage_skid.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 11;
  localparam int NW = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int pass  = 0;
  bit chk_on = 0;

  function automatic void chk(string n, logic [63:0] a,
                              logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endfunction

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] m_last = '0;
  int            m_stall = 0;
  int            m_flush = 0;

  // Model: the stage is a FIFO of depth two.
  always @(posedge clk) begin
    bit rdy, inf, outf;
    beat_t b;
    rdy  = !rst && q.size() < 2;
    inf  = in_valid && rdy;
    outf = q.size() > 0 && out_ready;
    if (rst) begin
      q.delete();
      m_last  = '0;
      m_stall = 0;
      m_flush = 0;
    end else if (flush) begin
      if ((q.size() > 0 || inf) && m_flush < SAT) m_flush++;
      q.delete();
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < SAT)
        m_stall++;
      if (outf) void'(q.pop_front());
      if (inf) begin
        b.c = in_ctrl;
        b.d = in_data;
        q.push_back(b);
      end
      if (q.size() > 0) m_last = q[0].d;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_in_ready", in_ready, !rst && q.size() < 2);
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_out_ctrl", out_ctrl,
          q.size() > 0 ? q[0].c : '0);
      chk("m_out_data", out_data,
          q.size() > 0 ? q[0].d : m_last);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_flush_cnt", flush_cnt, m_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic v, logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = CW'(d) | 11'h100;
  endtask

  int seq;

  initial begin
    rst = 1; flush = 0; out_ready = 0;
    drive(0, 0);
    tick();
    chk_on = 1;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 0;
    #1;
    chk("rst_fall_in_ready", in_ready, 1);
    tick();

    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, i);
      tick();
      chk("stream_data", out_data, i);
      chk("stream_valid", out_valid, 1);
    end
    drive(0, 0);
    tick();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_end_ctrl", out_ctrl, 0);
    chk("stream_end_data", out_data, 8);
    chk("stream_stall", stall_cnt, 0);

    out_ready = 0;
    drive(1, 'hA);
    tick();
    drive(1, 'hB);
    tick();
    drive(0, 0);
    tick();
    tick();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_held_a", out_data, 'hA);
    chk("bp_ctrl_a", out_ctrl, 11'h10A);
    chk("bp_stall", stall_cnt, 3);
    out_ready = 1;
    tick();
    chk("bp_emit_b", out_data, 'hB);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_drained", out_valid, 0);

    out_ready = 0;
    drive(1, 'h21);
    tick();
    drive(1, 'h22);
    tick();
    chk("fl_two", in_ready, 0);
    flush = 1;
    drive(1, 'h33);
    tick();
    flush = 0;
    drive(0, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_cnt", flush_cnt, 1);
    chk("fl_stall", stall_cnt, 4);
    out_ready = 1;
    tick();
    chk("fl_no_c", out_valid, 0);

    flush = 1;
    tick();
    chk("noop_flush_cnt", flush_cnt, 1);
    chk("noop_flush_valid", out_valid, 0);
    drive(1, 'h44);
    tick();
    flush = 0;
    drive(0, 0);
    chk("empty_fire_flush", flush_cnt, 2);
    chk("empty_fire_valid", out_valid, 0);

    out_ready = 0;
    drive(1, 'h55);
    tick();
    drive(0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", stall_cnt, 15);
    tick();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_data", out_data, 'h55);

    drive(1, 'h66);
    tick();
    drive(0, 0);
    chk("mid_two", in_ready, 0);
    rst = 1;
    tick();
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    chk("mid_ctrl", out_ctrl, 0);
    chk("mid_stall", stall_cnt, 0);
    chk("mid_flush", flush_cnt, 0);
    rst = 0;
    tick();
    chk("mid_in_ready", in_ready, 1);

    seq = 'h100;
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), seq);
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      seq++;
      tick();
    end
    flush = 0;
    out_ready = 1;
    drive(0, 0);
    tick();
    tick();
    tick();
    chk("mix_drained", out_valid, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning payload width in bits (PC+4, register data, immediate, instruction).
REQ-002 SHALL have parameter CTRL_W, default 11, meaning control-bundle width in bits (regDst, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of each statistics counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a beat this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-009 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port flush, input, 1, discard all held and incoming beats.
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-013 SHALL have port out_ctrl, output, CTRL_W, held control bundle.
REQ-014 SHALL have port out_data, output, DATA_W, held payload.
REQ-015 SHALL have port stall_cnt, output, CNT_W, count of back-pressure cycles.
REQ-016 SHALL have port flush_cnt, output, CNT_W, count of flushes that dropped at least one beat.

Function
REQ-017 SHALL hold up to two beats in a main register (drives outputs) and a skid register, tracked by state EMPTY, ONE or TWO.
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO and 0 while rst = 1, decoded from registered state only, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = 1 exactly in ONE and TWO.
REQ-021 SHALL present a beat on out_* the cycle after its in_fire when the stage was EMPTY, giving 1-cycle latency.
REQ-022 SHALL, in EMPTY, move to ONE on in_fire (main <= in) and otherwise stay EMPTY.
REQ-023 SHALL, in ONE, stay ONE with main <= in on in_fire & out_fire, move to TWO with skid <= in on in_fire & !out_ready, move to EMPTY on out_fire & !in_fire, and otherwise hold.
REQ-024 SHALL, in TWO, move to ONE with main <= skid on out_fire, and otherwise hold both registers.
REQ-025 SHALL preserve beat order, with no loss and no duplication, under any in_valid/out_ready pattern.
REQ-026 SHALL give flush top priority: next state EMPTY, both registers invalidated, and any same-cycle in_fire beat discarded.
REQ-027 SHALL force out_ctrl to all-zero whenever out_valid = 0, so that a bubble reads as a NOP.
REQ-028 SHALL keep out_data at its last value when empty, except after reset.
REQ-029 SHALL keep out_ctrl and out_data stable while out_valid & !out_ready.
REQ-030 SHALL increment stall_cnt by 1 each cycle with out_valid & !out_ready & !flush, saturating at all-ones.
REQ-031 SHALL increment flush_cnt by 1 each cycle with flush & (state != EMPTY or in_fire), saturating at all-ones.
REQ-032 SHALL treat flush with state EMPTY and no in_valid as a no-op that leaves flush_cnt unchanged.

Reset
REQ-033 SHALL, on a clock edge with rst = 1, set state EMPTY and drive out_valid = 0, out_ctrl = 0, out_data = 0, skid = 0, stall_cnt = 0 and flush_cnt = 0.
REQ-034 SHALL give rst priority over flush and all handshakes.
REQ-035 SHALL, on reset asserted mid-operation, drop held beats without counting them in flush_cnt.
REQ-036 SHALL drive in_ready = 1 on the first cycle after rst falls.

Verification
REQ-037 SHALL cover streaming: out_ready = 1, in_valid = 1 for 8 cycles, in_data = 1..8 -> out_data = 1..8 on consecutive cycles, each one cycle after entry; stall_cnt = 0.
REQ-038 SHALL cover back-pressure: beats A, B sent, out_ready = 0 for 3 cycles -> state TWO, in_ready = 0, out_data = A held, stall_cnt = 3; then out_ready = 1 -> A then B emitted, in_ready returns to 1.
REQ-039 SHALL cover flush: flush in state TWO with in_valid = 1 (beat C) -> next cycle out_valid = 0, out_ctrl = 0, C never emitted, flush_cnt = 1.
REQ-040 SHALL cover a no-op flush: flush in EMPTY with in_valid = 0 -> flush_cnt unchanged, out_valid = 0.
REQ-041 SHALL cover reset mid-operation: rst in state TWO -> all outputs zero next cycle, counters 0, in_ready = 1 the cycle after rst drops.
REQ-042 SHALL cover saturation: CNT_W = 4, out_ready = 0 for 20 cycles with a beat held -> stall_cnt = 15 and stays 15.
